// File: rtl/slv_pkg.sv
// Shared types and sizing for the monitor's ID slot allocator.
package slv_pkg;

  localparam int unsigned MaxUniqIds   = 2;
  localparam int unsigned MaxTxnsPerId = 4;
  localparam int unsigned IdWidth      = 6;
  localparam int unsigned IntIdWidth   = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
  localparam int unsigned CntSlotWidth = $clog2(MaxTxnsPerId + 1);

  typedef logic [IdWidth-1:0]      id_t;
  typedef logic [IntIdWidth-1:0]   intid_t;
  typedef logic [CntSlotWidth-1:0] cnt_t;

  typedef struct packed {
    logic valid;
    id_t  ext_id;
    cnt_t cnt;
  } slot_t;

endpackage

// File: rtl/slv_id_slot_alloc_lzc.sv
// Trailing-zero count: index of the lowest set bit, empty when no bit is set.
module slv_id_slot_alloc_lzc #(
  parameter int unsigned Width  = 2,
  parameter int unsigned CntW   = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        cnt_o   = CntW'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/slv_id_slot_alloc.sv
// Maps wide external AXI IDs onto a small set of internal ID slots, with
// per-slot outstanding counts, release tracking and reverse lookup.
module slv_id_slot_alloc #(
  parameter int unsigned MaxUniqIds   = 2,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned IdWidth      = 6,
  parameter int unsigned IntIdWidth   = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [IdWidth-1:0]    req_id_i,
  output logic                  req_ready_o,
  output logic [IntIdWidth-1:0] req_int_id_o,
  input  logic                  rel_valid_i,
  input  logic [IntIdWidth-1:0] rel_int_id_i,
  input  logic [IntIdWidth-1:0] lookup_int_id_i,
  output logic [IdWidth-1:0]    lookup_id_o,
  output logic                  busy_o,
  output logic                  full_o,
  output logic                  err_o
);

  import slv_pkg::*;

  slot_t [MaxUniqIds-1:0] slots_q, slots_d;

  logic [MaxUniqIds-1:0] valid_vec;
  logic [MaxUniqIds-1:0] hit_vec;
  logic [MaxUniqIds-1:0] inc_vec;
  logic [MaxUniqIds-1:0] dec_vec;
  logic                  any_hit;
  logic                  hit_full;
  logic [IntIdWidth-1:0] hit_idx;
  logic [IntIdWidth-1:0] free_idx;
  logic                  no_free;
  logic                  grant;
  logic                  rel_target_valid;

  // One-hot match of the request ID against valid entries.
  always_comb begin
    valid_vec = '0;
    hit_vec   = '0;
    any_hit   = 1'b0;
    hit_full  = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < int'(MaxUniqIds); i++) begin
      valid_vec[i] = slots_q[i].valid;
      hit_vec[i]   = slots_q[i].valid && (slots_q[i].ext_id == req_id_i);
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        hit_idx  = IntIdWidth'(i);
        hit_full = (slots_q[i].cnt == CntSlotWidth'(MaxTxnsPerId));
      end
    end
  end

  slv_id_slot_alloc_lzc #(
    .Width (MaxUniqIds),
    .CntW  (IntIdWidth)
  ) u_free_lzc (
    .in_i    (~valid_vec),
    .cnt_o   (free_idx),
    .empty_o (no_free)
  );

  // A hit never falls back to a free slot, keeping per-ID ordering intact.
  assign req_ready_o  = any_hit ? !hit_full : !no_free;
  assign req_int_id_o = any_hit ? hit_idx : free_idx;
  assign grant        = req_valid_i && req_ready_o;
  assign busy_o       = |valid_vec;
  assign full_o       = no_free;

  // Per-slot increment/decrement strobes and reverse lookup.
  always_comb begin
    inc_vec          = '0;
    dec_vec          = '0;
    rel_target_valid = 1'b0;
    lookup_id_o      = '0;
    for (int i = 0; i < int'(MaxUniqIds); i++) begin
      inc_vec[i] = grant && (req_int_id_o == IntIdWidth'(i));
      if (rel_int_id_i == IntIdWidth'(i)) begin
        rel_target_valid = slots_q[i].valid;
        dec_vec[i]       = rel_valid_i && slots_q[i].valid;
      end
      if (lookup_int_id_i == IntIdWidth'(i)) begin
        lookup_id_o = slots_q[i].ext_id;
      end
    end
  end

  // Table update; a simultaneous grant and release on one slot cancel out.
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < int'(MaxUniqIds); i++) begin
      if (inc_vec[i] && !dec_vec[i]) begin
        if (slots_q[i].valid) begin
          slots_d[i].cnt = slots_q[i].cnt + CntSlotWidth'(1);
        end else begin
          slots_d[i].valid  = 1'b1;
          slots_d[i].ext_id = req_id_i;
          slots_d[i].cnt    = CntSlotWidth'(1);
        end
      end else if (dec_vec[i] && !inc_vec[i]) begin
        slots_d[i].cnt = slots_q[i].cnt - CntSlotWidth'(1);
        if (slots_q[i].cnt == CntSlotWidth'(1)) begin
          slots_d[i].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q <= '0;
      err_o   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      err_o   <= rel_valid_i && !rel_target_valid;
    end
  end

endmodule

// File: tb/tb_slv_id_slot_alloc.sv
// Directed bench for the ID slot allocator with hand-computed expectations.
module tb_slv_id_slot_alloc;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic [5:0] req_id_i;
  logic       req_ready_o;
  logic       req_int_id_o;
  logic       rel_valid_i;
  logic       rel_int_id_i;
  logic       lookup_int_id_i;
  logic [5:0] lookup_id_o;
  logic       busy_o;
  logic       full_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  slv_id_slot_alloc dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_id_i        (req_id_i),
    .req_ready_o     (req_ready_o),
    .req_int_id_o    (req_int_id_o),
    .rel_valid_i     (rel_valid_i),
    .rel_int_id_i    (rel_int_id_i),
    .lookup_int_id_i (lookup_int_id_i),
    .lookup_id_o     (lookup_id_o),
    .busy_o          (busy_o),
    .full_o          (full_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // No two valid slots may ever carry the same external ID.
  task automatic check_unique;
    logic dup;
    dup = dut.slots_q[0].valid && dut.slots_q[1].valid &&
          (dut.slots_q[0].ext_id == dut.slots_q[1].ext_id);
    check("unique_id", 32'(dup), 32'd0);
  endtask

  task automatic drive(input logic rv, input logic [5:0] id, input logic lv, input logic lid);
    req_valid_i  = rv;
    req_id_i     = id;
    rel_valid_i  = lv;
    rel_int_id_i = lid;
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
    check_unique();
  endtask

  task automatic idle;
    drive(1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic grant(input string tag, input logic [5:0] id, input logic exp_slot);
    drive(1'b1, id, 1'b0, 1'b0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_int"}, 32'(req_int_id_o), 32'(exp_slot));
    tick();
    idle();
  endtask

  task automatic release_slot(input logic slot);
    drive(1'b0, 6'h00, 1'b1, slot);
    tick();
    idle();
  endtask

  initial begin
    rst_i           = 1'b1;
    lookup_int_id_i = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_lookup0", 32'(lookup_id_o), 32'h00);
    rst_i = 1'b0;

    // First grant lands in slot 0 with count 1.
    grant("first", 6'h2A, 1'b0);
    check("first_busy", 32'(busy_o), 32'd1);
    check("first_full", 32'(full_o), 32'd0);
    check("first_lookup", 32'(lookup_id_o), 32'h2A);

    // Hit plus release on the same slot at cnt=1 keeps it alive.
    drive(1'b1, 6'h2A, 1'b1, 1'b0);
    check("same_ready", 32'(req_ready_o), 32'd1);
    check("same_int", 32'(req_int_id_o), 32'd0);
    tick();
    idle();
    check("same_busy", 32'(busy_o), 32'd1);
    check("same_err", 32'(err_o), 32'd0);
    release_slot(1'b0);
    check("drain_busy", 32'(busy_o), 32'd0);

    // Per-ID cap of four outstanding, then stall until one release.
    for (int i = 0; i < 4; i++) grant("cap", 6'h05, 1'b0);
    drive(1'b1, 6'h05, 1'b0, 1'b0);
    check("cap_stall0", 32'(req_ready_o), 32'd0);
    tick();
    drive(1'b1, 6'h05, 1'b1, 1'b0);
    check("cap_stall1", 32'(req_ready_o), 32'd0);
    tick();
    drive(1'b1, 6'h05, 1'b0, 1'b0);
    check("cap_resume", 32'(req_ready_o), 32'd1);
    check("cap_int", 32'(req_int_id_o), 32'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) release_slot(1'b0);
    check("cap_busy3", 32'(busy_o), 32'd1);
    release_slot(1'b0);
    check("cap_busy4", 32'(busy_o), 32'd0);

    // Fill both slots, stall a third ID, free slot 1 and retry.
    grant("fill0", 6'h01, 1'b0);
    grant("fill1", 6'h02, 1'b1);
    check("fill_full", 32'(full_o), 32'd1);
    drive(1'b1, 6'h03, 1'b1, 1'b1);
    check("miss_stall", 32'(req_ready_o), 32'd0);
    tick();
    drive(1'b1, 6'h03, 1'b0, 1'b0);
    check("miss_ready", 32'(req_ready_o), 32'd1);
    check("miss_int", 32'(req_int_id_o), 32'd1);
    tick();
    idle();
    lookup_int_id_i = 1'b1;
    #1;
    check("lookup1", 32'(lookup_id_o), 32'h03);
    lookup_int_id_i = 1'b0;
    #1;
    check("lookup0", 32'(lookup_id_o), 32'h01);

    // Grant to slot 0 while slot 1 is released in the same cycle.
    drive(1'b1, 6'h01, 1'b1, 1'b1);
    check("ab_ready", 32'(req_ready_o), 32'd1);
    tick();
    idle();
    check("ab_full", 32'(full_o), 32'd0);
    check("ab_busy", 32'(busy_o), 32'd1);
    release_slot(1'b0);
    check("ab_busy1", 32'(busy_o), 32'd1);
    release_slot(1'b0);
    check("ab_busy0", 32'(busy_o), 32'd0);

    // Illegal release of an empty slot pulses err for one cycle.
    drive(1'b0, 6'h00, 1'b1, 1'b1);
    check("err_pre", 32'(err_o), 32'd0);
    tick();
    idle();
    check("err_pulse", 32'(err_o), 32'd1);
    check("err_busy", 32'(busy_o), 32'd0);
    tick();
    check("err_clear", 32'(err_o), 32'd0);
    lookup_int_id_i = 1'b1;
    #1;
    check("err_lookup_hold", 32'(lookup_id_o), 32'h03);

    // Asynchronous reset with both slots at cnt=3.
    for (int i = 0; i < 3; i++) grant("pre_a", 6'h0A, 1'b0);
    for (int i = 0; i < 3; i++) grant("pre_b", 6'h0B, 1'b1);
    check("pre_full", 32'(full_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_full", 32'(full_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    check("arst_lookup1", 32'(lookup_id_o), 32'h00);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    grant("post_rst", 6'h0B, 1'b0);
    lookup_int_id_i = 1'b0;
    #1;
    check("post_lookup", 32'(lookup_id_o), 32'h0B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
